axi_sort_dma_master: RTL and testbench

- AXI4-lite initiator that drives the bitonic sort peripheral's memory-mapped register map without CPU involvement.
- On a start command it resets the sorter, copies 2**LOG_INPUT_NUM words from main memory into the sorter input registers, triggers the sort, and polls for completion.
- It then copies the sorted results to a destination buffer.
- Sits on the same AXI4-lite bus as the memory/peripheral responder, in place of (or arbitrated with) the CPU.

---
 rtl/axi_sort_dma_master_if.sv | 40 ++++
 rtl/axi_sort_dma_master.sv | 163 ++++++++++++++++
 tb/tb_axi_sort_dma_master.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sort_dma_master_if.sv
// axi_sort_dma_master_if: AXI4-lite channel bundle between the sort DMA master and its responder
// Ports (modport master drives, slave receives):
//   AW: mem_axi_awvalid/awaddr/awprot out, mem_axi_awready in
//   W : mem_axi_wvalid/wdata/wstrb out, mem_axi_wready in
//   B : mem_axi_bready out, mem_axi_bvalid in
//   AR: mem_axi_arvalid/araddr/arprot out, mem_axi_arready in
//   R : mem_axi_rready out, mem_axi_rvalid/rdata in
interface axi_sort_dma_master_if;
    logic        mem_axi_awvalid;
    logic        mem_axi_awready;
    logic [31:0] mem_axi_awaddr;
    logic [2:0]  mem_axi_awprot;
    logic        mem_axi_wvalid;
    logic        mem_axi_wready;
    logic [31:0] mem_axi_wdata;
    logic [3:0]  mem_axi_wstrb;
    logic        mem_axi_bvalid;
    logic        mem_axi_bready;
    logic        mem_axi_arvalid;
    logic        mem_axi_arready;
    logic [31:0] mem_axi_araddr;
    logic [2:0]  mem_axi_arprot;
    logic        mem_axi_rvalid;
    logic        mem_axi_rready;
    logic [31:0] mem_axi_rdata;
    modport master (
        output mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot, mem_axi_wvalid, mem_axi_wdata,
               mem_axi_wstrb, mem_axi_bready, mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
               mem_axi_rready,
        input  mem_axi_awready, mem_axi_wready, mem_axi_bvalid, mem_axi_arready, mem_axi_rvalid,
               mem_axi_rdata
    );
    modport slave (
        input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot, mem_axi_wvalid, mem_axi_wdata,
               mem_axi_wstrb, mem_axi_bready, mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
               mem_axi_rready,
        output mem_axi_awready, mem_axi_wready, mem_axi_bvalid, mem_axi_arready, mem_axi_rvalid,
               mem_axi_rdata
    );
endinterface

// File: rtl/axi_sort_dma_master.sv
// axi_sort_dma_master: AXI4-lite initiator that loads, triggers, polls and unloads the bitonic sorter
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : command strobe, sampled only when idle
//   src_addr        : byte address of first unsorted word
//   dst_addr        : byte address for sorted word 0
//   busy/done/error : command in progress / end-of-command pulse / poll-limit failure pulse
//   bus             : AXI4-lite master port, one transaction outstanding at a time
module axi_sort_dma_master #(
    parameter int          LOG_INPUT_NUM = 4,
    parameter logic [31:0] SORT_BASE     = 32'h4000_0000,
    parameter logic [31:0] RES_BASE      = 32'h5000_0004,
    parameter int          POLL_LIMIT    = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [31:0]                  src_addr,
    input  logic [31:0]                  dst_addr,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    axi_sort_dma_master_if.master        bus
);
    typedef enum logic [3:0] {
        IDLE, RST_ON, RST_OFF, LOAD_RD, LOAD_WR, TRIGGER, POLL, UNLOAD_RD, UNLOAD_WR, FINISH
    } state_t;
    localparam logic [LOG_INPUT_NUM-1:0] ONE = 1;
    state_t                   state;
    logic [LOG_INPUT_NUM-1:0] idx;
    logic [31:0]              src, dst, hold, poll_cnt;
    logic                     issued;
    logic [31:0]              off, wr_addr, wr_data, rd_addr;
    logic                     is_wr, is_rd, last, aw_left, w_left, wr_ok, rd_ok;
    assign bus.mem_axi_awprot = 3'b000;
    assign bus.mem_axi_arprot = 3'b000;
    assign bus.mem_axi_wstrb  = 4'hF;
    always_comb begin
        off     = 32'(idx) << 2;
        is_wr   = state inside {RST_ON, RST_OFF, LOAD_WR, TRIGGER, UNLOAD_WR};
        is_rd   = state inside {LOAD_RD, POLL, UNLOAD_RD};
        wr_addr = state == LOAD_WR   ? SORT_BASE + 32'd8 + off :
                  state == TRIGGER   ? SORT_BASE + 32'd4 :
                  state == UNLOAD_WR ? dst + off : SORT_BASE;
        wr_data = state inside {RST_ON, TRIGGER} ? 32'd1 : state == RST_OFF ? 32'd0 : hold;
        rd_addr = state == LOAD_RD ? src + off : state == UNLOAD_RD ? RES_BASE + off : SORT_BASE;
        last    = &idx;
        aw_left = bus.mem_axi_awvalid && !bus.mem_axi_awready;
        w_left  = bus.mem_axi_wvalid && !bus.mem_axi_wready;
        wr_ok   = bus.mem_axi_bready && bus.mem_axi_bvalid;
        rd_ok   = bus.mem_axi_rready && bus.mem_axi_rvalid;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            idx                 <= '0;
            src                 <= '0;
            dst                 <= '0;
            hold                <= '0;
            poll_cnt            <= '0;
            issued              <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            error               <= 1'b0;
            bus.mem_axi_awvalid <= 1'b0;
            bus.mem_axi_awaddr  <= '0;
            bus.mem_axi_wvalid  <= 1'b0;
            bus.mem_axi_wdata   <= '0;
            bus.mem_axi_bready  <= 1'b0;
            bus.mem_axi_arvalid <= 1'b0;
            bus.mem_axi_araddr  <= '0;
            bus.mem_axi_rready  <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            // issue cycle, then AW and W retire independently; B is accepted only after both
            if (is_wr) begin
                if (!issued) begin
                    issued              <= 1'b1;
                    bus.mem_axi_awvalid <= 1'b1;
                    bus.mem_axi_wvalid  <= 1'b1;
                    bus.mem_axi_awaddr  <= wr_addr;
                    bus.mem_axi_wdata   <= wr_data;
                end else begin
                    bus.mem_axi_awvalid <= aw_left;
                    bus.mem_axi_wvalid  <= w_left;
                    if ((bus.mem_axi_awvalid || bus.mem_axi_wvalid) && !aw_left && !w_left)
                        bus.mem_axi_bready <= 1'b1;
                    if (wr_ok) begin
                        bus.mem_axi_bready <= 1'b0;
                        issued             <= 1'b0;
                    end
                end
            end
            if (is_rd) begin
                if (!issued) begin
                    issued              <= 1'b1;
                    bus.mem_axi_arvalid <= 1'b1;
                    bus.mem_axi_araddr  <= rd_addr;
                end else begin
                    if (bus.mem_axi_arvalid && bus.mem_axi_arready) begin
                        bus.mem_axi_arvalid <= 1'b0;
                        bus.mem_axi_rready  <= 1'b1;
                    end
                    if (rd_ok) begin
                        bus.mem_axi_rready <= 1'b0;
                        issued             <= 1'b0;
                    end
                end
            end
            case (state)
                IDLE: if (start) begin
                    src   <= src_addr;
                    dst   <= dst_addr;
                    idx   <= '0;
                    busy  <= 1'b1;
                    state <= RST_ON;
                end
                RST_ON:  if (wr_ok) state <= RST_OFF;
                RST_OFF: if (wr_ok) state <= LOAD_RD;
                LOAD_RD: if (rd_ok) begin
                    hold  <= bus.mem_axi_rdata;
                    state <= LOAD_WR;
                end
                LOAD_WR: if (wr_ok) begin
                    idx   <= last ? '0 : idx + ONE;
                    state <= last ? TRIGGER : LOAD_RD;
                end
                TRIGGER: if (wr_ok) begin
                    poll_cnt <= '0;
                    state    <= POLL;
                end
                POLL: if (rd_ok) begin
                    if (bus.mem_axi_rdata[0]) begin
                        state <= UNLOAD_RD;
                    end else if (poll_cnt == 32'(POLL_LIMIT - 1)) begin
                        state <= FINISH;
                        done  <= 1'b1;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        poll_cnt <= poll_cnt + 32'd1;
                    end
                end
                UNLOAD_RD: if (rd_ok) begin
                    hold  <= bus.mem_axi_rdata;
                    state <= UNLOAD_WR;
                end
                UNLOAD_WR: if (wr_ok) begin
                    if (last) begin
                        state <= FINISH;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        idx   <= idx + ONE;
                        state <= UNLOAD_RD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_sort_dma_master.sv
// tb_axi_sort_dma_master: randomized bench with a memory + sorter responder and a transaction-level model
module tb_axi_sort_dma_master;
    localparam int          N          = 16;
    localparam logic [31:0] SORT_BASE  = 32'h4000_0000;
    localparam logic [31:0] RES_BASE   = 32'h5000_0004;
    localparam int          POLL_LIMIT = 1024;
    localparam int          NWRITES    = 2 + N + 1 + N;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] src_addr = '0, dst_addr = '0;
    logic        busy, done, error;

    axi_sort_dma_master_if bus();

    axi_sort_dma_master dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .busy(busy), .done(done), .error(error), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        trace[$];
    txn_t        exp_q[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] sin[N];
    logic [31:0] sres[N];
    int          polls, poll_zero, aw_stall, w_stall, aw_wait, w_wait, b_count;
    bit          never_valid, have_aw, have_w;
    logic [31:0] aw_q, w_q;
    int          compared = 0, mismatched = 0;

    // ---------------- responder: memory plus sorter register map ----------------
    function automatic void do_write(input logic [31:0] a, input logic [31:0] d);
        trace.push_back(txn_t'{1'b1, a, d});
        if (a == SORT_BASE) begin
            polls = 0;
        end else if (a == SORT_BASE + 32'd4) begin
            logic [31:0] q[$];
            for (int i = 0; i < N; i++) q.push_back(sin[i]);
            q.sort();
            for (int i = 0; i < N; i++) sres[i] = q[i];
        end else if (a >= SORT_BASE + 32'd8 && a < SORT_BASE + 32'd8 + 32'(4 * N)) begin
            sin[int'((a - SORT_BASE - 32'd8) >> 2)] = d;
        end else begin
            mem[a] = d;
        end
    endfunction

    function automatic logic [31:0] do_read(input logic [31:0] a);
        logic [31:0] r;
        if (a == SORT_BASE) begin
            polls++;
            r = {31'b0, !never_valid && polls > poll_zero};
        end else if (a >= RES_BASE && a < RES_BASE + 32'(4 * N)) begin
            r = sres[int'((a - RES_BASE) >> 2)];
        end else begin
            r = mem.exists(a) ? mem[a] : 32'd0;
        end
        trace.push_back(txn_t'{1'b0, a, r});
        return r;
    endfunction

    assign bus.mem_axi_awready = bus.mem_axi_awvalid && aw_wait >= aw_stall;
    assign bus.mem_axi_wready  = bus.mem_axi_wvalid && w_wait >= w_stall;
    assign bus.mem_axi_arready = bus.mem_axi_arvalid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_wait <= 0;
            w_wait <= 0;
            have_aw <= 1'b0;
            have_w <= 1'b0;
            bus.mem_axi_bvalid <= 1'b0;
            bus.mem_axi_rvalid <= 1'b0;
            bus.mem_axi_rdata <= '0;
        end else begin
            if (bus.mem_axi_awvalid && bus.mem_axi_awready) begin
                aw_q <= bus.mem_axi_awaddr;
                have_aw <= 1'b1;
                aw_wait <= 0;
            end else if (bus.mem_axi_awvalid) aw_wait <= aw_wait + 1;
            if (bus.mem_axi_wvalid && bus.mem_axi_wready) begin
                w_q <= bus.mem_axi_wdata;
                have_w <= 1'b1;
                w_wait <= 0;
            end else if (bus.mem_axi_wvalid) w_wait <= w_wait + 1;
            if (have_aw && have_w) begin
                do_write(aw_q, w_q);
                have_aw <= 1'b0;
                have_w <= 1'b0;
                bus.mem_axi_bvalid <= 1'b1;
            end
            if (bus.mem_axi_bvalid && bus.mem_axi_bready) begin
                bus.mem_axi_bvalid <= 1'b0;
                b_count <= b_count + 1;
            end
            if (bus.mem_axi_arvalid && bus.mem_axi_arready) begin
                bus.mem_axi_rdata <= do_read(bus.mem_axi_araddr);
                bus.mem_axi_rvalid <= 1'b1;
            end
            if (bus.mem_axi_rvalid && bus.mem_axi_rready) bus.mem_axi_rvalid <= 1'b0;
        end
    end

    // ---------------- monitor: valid durations, stability, pulses ----------------
    int          aw_run = 0, w_run = 0, aw_bad = 0, w_bad = 0, unstable = 0, done_cnt = 0;
    bit          p_aw = 0, p_w = 0;
    logic [31:0] p_awaddr, p_wdata;

    always @(negedge clk) begin
        if (bus.mem_axi_awvalid) aw_run++;
        else if (aw_run > 0) begin
            if (aw_run != aw_stall + 1) aw_bad++;
            aw_run = 0;
        end
        if (bus.mem_axi_wvalid) w_run++;
        else if (w_run > 0) begin
            if (w_run != w_stall + 1) w_bad++;
            w_run = 0;
        end
        if (bus.mem_axi_awvalid && p_aw && bus.mem_axi_awaddr !== p_awaddr) unstable++;
        if (bus.mem_axi_wvalid && p_w && bus.mem_axi_wdata !== p_wdata) unstable++;
        p_aw = bus.mem_axi_awvalid;
        p_w = bus.mem_axi_wvalid;
        p_awaddr = bus.mem_axi_awaddr;
        p_wdata = bus.mem_axi_wdata;
        if (done) done_cnt++;
    end

    // ---------------- reference model: expected bus trace from the command rules ----------------
    task automatic build_exp(input logic [31:0] s, input logic [31:0] d, input int nzero, input bit found);
        logic [31:0] v[$];
        logic [31:0] a, x;
        exp_q.push_back(txn_t'{1'b1, SORT_BASE, 32'd1});
        exp_q.push_back(txn_t'{1'b1, SORT_BASE, 32'd0});
        for (int i = 0; i < N; i++) begin
            a = s + 32'(4 * i);
            x = mem.exists(a) ? mem[a] : 32'd0;
            v.push_back(x);
            exp_q.push_back(txn_t'{1'b0, a, x});
            exp_q.push_back(txn_t'{1'b1, SORT_BASE + 32'd8 + 32'(4 * i), x});
        end
        exp_q.push_back(txn_t'{1'b1, SORT_BASE + 32'd4, 32'd1});
        if (!found) begin
            for (int k = 0; k < POLL_LIMIT; k++) exp_q.push_back(txn_t'{1'b0, SORT_BASE, 32'd0});
            return;
        end
        for (int k = 0; k <= nzero; k++) exp_q.push_back(txn_t'{1'b0, SORT_BASE, k == nzero ? 32'd1 : 32'd0});
        v.sort();
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(txn_t'{1'b0, RES_BASE + 32'(4 * i), v[i]});
            exp_q.push_back(txn_t'{1'b1, d + 32'(4 * i), v[i]});
        end
    endtask

    function automatic int trace_diff();
        int n = (trace.size() == exp_q.size()) ? 0 : 1;
        for (int i = 0; i < trace.size() && i < exp_q.size(); i++)
            if (trace[i].wr !== exp_q[i].wr || trace[i].addr !== exp_q[i].addr || trace[i].data !== exp_q[i].data) n++;
        return n;
    endfunction

    task automatic fill(input logic [31:0] s, input bit desc);
        for (int i = 0; i < N; i++) mem[s + 32'(4 * i)] = desc ? 32'(N - i) : $urandom;
    endtask

    task automatic setup(input int aws, input int ws, input int pz, input bit nv);
        aw_stall = aws;
        w_stall = ws;
        poll_zero = pz;
        never_valid = nv;
        trace.delete();
        exp_q.delete();
    endtask

    task automatic start_cmd(input logic [31:0] s, input logic [31:0] d, output bit b);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b = busy;
        src_addr = $urandom;
        dst_addr = $urandom;
    endtask

    task automatic wait_done(output bit ok, output bit err);
        ok = 1'b0;
        err = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                err = error;
                break;
            end
        end
    endtask

    task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, output bit ok, output bit err, output bit b);
        start_cmd(s, d, b);
        wait_done(ok, err);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        compared++;
        if ({bus.mem_axi_awvalid, bus.mem_axi_wvalid, bus.mem_axi_bready, bus.mem_axi_arvalid,
             bus.mem_axi_rready, busy, done, error} !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b required 00000000", {bus.mem_axi_awvalid, bus.mem_axi_wvalid,
                     bus.mem_axi_bready, bus.mem_axi_arvalid, bus.mem_axi_rready, busy, done, error});
        end
        compared++;
        if ({bus.mem_axi_awaddr, bus.mem_axi_wdata, bus.mem_axi_araddr} !== 96'h0) begin
            mismatched++;
            $display("FAIL reset_addr: got %h %h %h required 0", bus.mem_axi_awaddr, bus.mem_axi_wdata, bus.mem_axi_araddr);
        end
        rst = 1'b0;
    endtask

    task automatic test_sort_basic();
        bit ok, err, b;
        int d0, bad;
        setup(0, 0, 0, 0);
        fill(32'h1000, 1'b1);
        build_exp(32'h1000, 32'h2000, 0, 1'b1);
        d0 = done_cnt;
        run_cmd(32'h1000, 32'h2000, ok, err, b);
        repeat (3) @(negedge clk);
        compared++;
        if (b !== 1'b1) begin mismatched++; $display("FAIL basic_busy: got %b required 1", b); end
        compared++;
        if ({ok, err} !== 2'b10) begin mismatched++; $display("FAIL basic_done_err: got %b required 10", {ok, err}); end
        compared++;
        if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL basic_done_count: got %0d required 1", done_cnt - d0); end
        bad = trace_diff();
        compared++;
        if (bad !== 0) begin mismatched++; $display("FAIL basic_trace: got %0d differing entries (len %0d) required 0 (len %0d)", bad, trace.size(), exp_q.size()); end
        bad = 0;
        for (int i = 0; i < N; i++) if (mem[32'h2000 + 32'(4 * i)] !== 32'(i + 1)) bad++;
        compared++;
        if (bad !== 0) begin mismatched++; $display("FAIL basic_dst: got %0d wrong words required 0", bad); end
    endtask

    task automatic test_random();
        bit ok, err, b;
        int bad;
        logic [31:0] s, d;
        for (int t = 0; t < 3; t++) begin
            setup($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), 0);
            s = $urandom & 32'h0FFF_FFC0;
            d = s ^ 32'h1000_0000;
            fill(s, 1'b0);
            build_exp(s, d, poll_zero, 1'b1);
            run_cmd(s, d, ok, err, b);
            repeat (3) @(negedge clk);
            bad = trace_diff();
            compared++;
            if ({ok, err} !== 2'b10 || bad !== 0) begin
                mismatched++;
                $display("FAIL random_%0d: got done/err %b diff %0d required 10 diff 0", t, {ok, err}, bad);
            end
        end
    endtask

    task automatic test_stall();
        bit ok, err, b;
        int b0, bad;
        setup(3, 0, 1, 0);
        fill(32'h3000, 1'b0);
        build_exp(32'h3000, 32'h6000, 1, 1'b1);
        aw_bad = 0; w_bad = 0; unstable = 0; b0 = b_count;
        run_cmd(32'h3000, 32'h6000, ok, err, b);
        repeat (3) @(negedge clk);
        compared++;
        if (aw_bad !== 0 || w_bad !== 0) begin mismatched++; $display("FAIL stall_lengths: got aw_bad %0d w_bad %0d required 0 0", aw_bad, w_bad); end
        compared++;
        if (unstable !== 0) begin mismatched++; $display("FAIL stall_stable: got %0d changes required 0", unstable); end
        compared++;
        if (b_count - b0 !== NWRITES) begin mismatched++; $display("FAIL stall_bresp: got %0d required %0d", b_count - b0, NWRITES); end
        bad = trace_diff();
        compared++;
        if ({ok, err} !== 2'b10 || bad !== 0) begin mismatched++; $display("FAIL stall_trace: got done/err %b diff %0d required 10 diff 0", {ok, err}, bad); end
    endtask

    task automatic test_poll();
        bit ok, err, b;
        int n;
        setup(0, 0, 5, 0);
        fill(32'h7000, 1'b0);
        build_exp(32'h7000, 32'h8000, 5, 1'b1);
        run_cmd(32'h7000, 32'h8000, ok, err, b);
        repeat (3) @(negedge clk);
        n = 0;
        foreach (trace[i]) if (!trace[i].wr && trace[i].addr == SORT_BASE) n++;
        compared++;
        if (n !== 6) begin mismatched++; $display("FAIL poll_count: got %0d required 6", n); end
        n = trace_diff();
        compared++;
        if ({ok, err} !== 2'b10 || n !== 0) begin mismatched++; $display("FAIL poll_trace: got done/err %b diff %0d required 10 diff 0", {ok, err}, n); end
    endtask

    task automatic test_poll_limit();
        bit ok, err, b;
        int n, w;
        setup(0, 0, 0, 1);
        fill(32'h9000, 1'b0);
        build_exp(32'h9000, 32'hA000, 0, 1'b0);
        run_cmd(32'h9000, 32'hA000, ok, err, b);
        repeat (3) @(negedge clk);
        compared++;
        if ({ok, err} !== 2'b11) begin mismatched++; $display("FAIL limit_done_err: got %b required 11", {ok, err}); end
        n = 0; w = 0;
        foreach (trace[i]) begin
            if (!trace[i].wr && trace[i].addr == SORT_BASE) n++;
            if (trace[i].wr && trace[i].addr >= 32'hA000 && trace[i].addr < 32'hA000 + 32'(4 * N)) w++;
        end
        compared++;
        if (n !== POLL_LIMIT || w !== 0) begin mismatched++; $display("FAIL limit_polls: got polls %0d dst writes %0d required %0d 0", n, w, POLL_LIMIT); end
        n = trace_diff();
        compared++;
        if (n !== 0) begin mismatched++; $display("FAIL limit_trace: got %0d differing entries required 0", n); end
    endtask

    task automatic test_wrap();
        bit ok, err, b;
        int n;
        setup(0, 0, 0, 0);
        fill(32'hFFFF_FFF8, 1'b0);
        build_exp(32'hFFFF_FFF8, 32'h0000_B000, 0, 1'b1);
        run_cmd(32'hFFFF_FFF8, 32'h0000_B000, ok, err, b);
        repeat (3) @(negedge clk);
        compared++;
        if (trace.size() < 7) begin
            mismatched++;
            $display("FAIL wrap_addrs: got %0d transactions required at least 7", trace.size());
        end else if ({trace[2].addr, trace[4].addr, trace[6].addr} !== {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000}) begin
            mismatched++;
            $display("FAIL wrap_addrs: got %h %h %h required fffffff8 fffffffc 00000000", trace[2].addr, trace[4].addr, trace[6].addr);
        end
        n = trace_diff();
        compared++;
        if ({ok, err} !== 2'b10 || n !== 0) begin mismatched++; $display("FAIL wrap_trace: got done/err %b diff %0d required 10 diff 0", {ok, err}, n); end
    endtask

    task automatic test_reset_mid();
        bit ok, err, b, hit;
        int d0, n;
        setup(0, 0, 0, 0);
        fill(32'hC000, 1'b0);
        start_cmd(32'hC000, 32'hD000, b);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (bus.mem_axi_awvalid && bus.mem_axi_awaddr == SORT_BASE + 32'd8 + 32'd20) hit = 1'b1;
        end
        compared++;
        if (!hit) begin mismatched++; $display("FAIL midrst_reach: got no LOAD_WR idx5 write required one"); end
        d0 = done_cnt;
        #1 rst = 1'b1;
        #1;
        compared++;
        if ({bus.mem_axi_awvalid, bus.mem_axi_wvalid, bus.mem_axi_bready, bus.mem_axi_arvalid,
             bus.mem_axi_rready, busy, done} !== 7'h00) begin
            mismatched++;
            $display("FAIL midrst_outputs: got %b required 0000000", {bus.mem_axi_awvalid, bus.mem_axi_wvalid,
                     bus.mem_axi_bready, bus.mem_axi_arvalid, bus.mem_axi_rready, busy, done});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        compared++;
        if (done_cnt !== d0 || busy !== 1'b0) begin mismatched++; $display("FAIL midrst_quiet: got done delta %0d busy %b required 0 0", done_cnt - d0, busy); end
        trace.delete();
        build_exp(32'hC000, 32'hD000, 0, 1'b1);
        run_cmd(32'hC000, 32'hD000, ok, err, b);
        repeat (3) @(negedge clk);
        n = trace_diff();
        compared++;
        if ({ok, err} !== 2'b10 || n !== 0) begin mismatched++; $display("FAIL midrst_rerun: got done/err %b diff %0d required 10 diff 0", {ok, err}, n); end
    endtask

    task automatic test_back_to_back();
        txn_t one[$];
        int dn, n;
        bit bad_err;
        setup(0, 0, 2, 0);
        fill(32'hE000, 1'b0);
        build_exp(32'hE000, 32'hF000, 2, 1'b1);
        one = exp_q;
        foreach (one[i]) exp_q.push_back(one[i]);
        @(negedge clk);
        src_addr = 32'hE000;
        dst_addr = 32'hF000;
        start = 1'b1;
        dn = 0;
        bad_err = 1'b0;
        for (int i = 0; i < 30000 && dn < 2; i++) begin
            @(negedge clk);
            if (done) begin
                dn++;
                if (error) bad_err = 1'b1;
                if (dn == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        compared++;
        if (dn !== 2 || bad_err !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_done: got dones %0d err %b busy %b required 2 0 0", dn, bad_err, busy);
        end
        n = trace_diff();
        compared++;
        if (n !== 0) begin mismatched++; $display("FAIL b2b_trace: got %0d differing entries required 0", n); end
    endtask

    initial begin
        b_count = 0;
        setup(0, 0, 0, 0);
        test_reset();
        test_sort_basic();
        test_random();
        test_stall();
        test_poll();
        test_poll_limit();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
